// File: rtl/frv_fetch_redirect.sv
// Fetch front end: owns the fetch PC, issues word fetches, buffers responses in order
// towards decode, and restarts at a writeback-requested target once the redirect is acked.
module frv_fetch_redirect #(
    parameter logic [31:0] PC_RESET = 32'h8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cf_req,
    input  logic [31:0] cf_target,
    output logic        cf_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_recv,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [31:0] f_data,
    output logic [31:0] f_pc,
    output logic        f_error,
    output logic        flush
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0] CAP = SW'(DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } fetch_word_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q;
    logic          req_pending_q, flush_q;
    logic [31:0]   tag_mem [DEPTH];
    logic [AW-1:0] tag_wr_q, tag_rd_q;
    fetch_word_t   fifo_mem [DEPTH];
    logic [CW-1:0] fifo_wr_q, fifo_rd_q, fifo_count;
    logic          run, credit, grant, fifo_push, fifo_pop;
    fetch_word_t   head;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    always_comb begin
        run        = (state_q == RUN);
        fifo_count = fifo_wr_q - fifo_rd_q;
        credit     = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CAP;
        // A pending request is never withdrawn; a fresh one yields to a redirect.
        imem_req   = req_pending_q || (run && credit && !cf_req);
        cf_ack     = run && cf_req && !(req_pending_q && !imem_gnt);
        grant      = imem_req && imem_gnt;
        f_valid    = (fifo_count != '0);
        fifo_pop   = f_valid && f_ready && !cf_ack;
        fifo_push  = imem_recv && (discard_q == '0) && !cf_ack;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_recv);
    end

    assign imem_addr = pc_q;
    assign head      = fifo_mem[fifo_rd_q[AW-1:0]];
    assign f_data    = head.data;
    assign f_pc      = head.pc;
    assign f_error   = head.err;
    assign flush     = flush_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q       <= BOOT;
            pc_q          <= PC_RESET;
            outstanding_q <= '0;
            discard_q     <= '0;
            req_pending_q <= 1'b0;
            flush_q       <= 1'b0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            req_pending_q <= imem_req && !imem_gnt;
            flush_q       <= cf_ack;
            if (grant)
                tag_wr_q <= tag_wr_q + AW'(1);
            if (imem_recv)
                tag_rd_q <= tag_rd_q + AW'(1);
            if (cf_ack) begin
                // Everything granted up to and including this cycle is now stale.
                pc_q      <= cf_target & ~32'd3;
                discard_q <= outstanding_d;
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
            end else begin
                if (grant)
                    pc_q <= pc_q + 32'd4;
                if (imem_recv && discard_q != '0)
                    discard_q <= discard_q - CW'(1);
                if (fifo_push)
                    fifo_wr_q <= fifo_wr_q + CW'(1);
                if (fifo_pop)
                    fifo_rd_q <= fifo_rd_q + CW'(1);
            end
        end
    end

    // NOTE: storage arrays are not reset; the pointers alone decide which entries are live.
    always_ff @(posedge g_clk) begin
        if (grant)
            tag_mem[tag_wr_q] <= pc_q;
        if (fifo_push)
            fifo_mem[fifo_wr_q[AW-1:0]] <= '{data: imem_rdata, pc: tag_mem[tag_rd_q], err: imem_error};
    end

    always_ff @(posedge g_clk) begin
        if (g_resetn)
            orphan_recv: assert (!(imem_recv && outstanding_q == '0));
    end
endmodule

// File: tb/tb_frv_fetch_redirect.sv
// Randomized scoreboard bench for frv_fetch_redirect: epoch-tagged in-flight model,
// expected-word queue, and a memory model that answers granted fetches in order.
module tb_frv_fetch_redirect;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam int DEPTH = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        cf_req = 1'b0;
    logic [31:0] cf_target = '0;
    logic        cf_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_recv = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_error = 1'b0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [31:0] f_data;
    logic [31:0] f_pc;
    logic        f_error;
    logic        flush;

    frv_fetch_redirect #(.PC_RESET(PC_RESET), .DEPTH(DEPTH)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cf_req(cf_req), .cf_target(cf_target), .cf_ack(cf_ack),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_recv(imem_recv), .imem_rdata(imem_rdata), .imem_error(imem_error),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data), .f_pc(f_pc),
        .f_error(f_error), .flush(flush)
    );

    always #5 g_clk = ~g_clk;

    typedef struct { logic [31:0] addr; int ready; } mreq_t;
    typedef struct { logic [31:0] pc; int epoch; } infl_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; logic err; } word_t;

    mreq_t mem_q[$];
    infl_t infl_q[$];
    word_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_grant_sr = -1;

    int gnt_pct = 0, recv_pct = 100, ready_pct = 100, cf_pct = 0;
    int lat_min = 1, lat_max = 1;
    bit hold_recv = 1'b0, rst_drive = 1'b0, force_cf = 1'b0;
    logic [31:0] force_target = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        t = $urandom;
        case ($urandom_range(3))
            0: return 32'hFFFF_FFF0 | (t & 32'hF);
            1: return 32'h0000_1000 | (t & 32'hFF);
            default: return t;
        endcase
    endfunction

    // Drives one cycle of stimulus at the falling edge; memory answers in order.
    task automatic step();
        @(negedge g_clk);
        g_resetn = rst_drive;
        if (!rst_drive)
            mem_q.delete();
        imem_gnt = ($urandom_range(99) < gnt_pct);
        f_ready  = ($urandom_range(99) < ready_pct);
        if (force_cf) begin
            cf_req = 1'b1;
            cf_target = force_target;
        end else if ($urandom_range(99) < cf_pct) begin
            cf_req = 1'b1;
            cf_target = pick_target();
        end else begin
            cf_req = 1'b0;
            cf_target = $urandom;
        end
        imem_recv  = 1'b0;
        imem_rdata = $urandom;
        imem_error = 1'b0;
        if (rst_drive && !hold_recv && mem_q.size() > 0 && mem_q[0].ready <= cyc + 1
            && $urandom_range(99) < recv_pct) begin
            imem_recv  = 1'b1;
            imem_error = (mem_q[0].addr == 32'h8000_0010) || ($urandom_range(15) == 0);
            void'(mem_q.pop_front());
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Monitor/scoreboard: samples 1ns after the falling edge, i.e. the values the next rising edge acts on.
    initial begin : monitor
        logic        running, exp_req, exp_ack, prev_pending, prev_ack;
        logic [31:0] exp_pc;
        int          since_rst, epoch;
        word_t       w;
        infl_t       it;
        mreq_t       m;
        prev_pending = 1'b0;
        prev_ack     = 1'b0;
        exp_pc       = PC_RESET;
        since_rst    = 0;
        epoch        = 0;
        forever begin
            @(negedge g_clk);
            #1;
            cyc++;
            if (!g_resetn) begin
                infl_q.delete();
                exp_q.delete();
                since_rst      = 0;
                exp_pc         = PC_RESET;
                prev_pending   = 1'b0;
                prev_ack       = 1'b0;
                first_grant_sr = -1;
            end else begin
                since_rst++;
                running = (since_rst >= 2);
                exp_req = prev_pending ||
                          (running && !cf_req && (infl_q.size() + exp_q.size() < DEPTH));
                exp_ack = running && cf_req && !(exp_req && !imem_gnt);
                check("imem_req", imem_req, exp_req);
                check("cf_ack", cf_ack, exp_ack);
                check("flush", flush, prev_ack);
                check("f_valid", f_valid, exp_q.size() != 0);
                if (imem_req)
                    check("imem_addr", imem_addr, exp_pc);
                if (f_valid && f_ready && !cf_ack && exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("f_data", f_data, w.data);
                    check("f_pc", f_pc, w.pc);
                    check("f_error", f_error, w.err);
                end
                if (imem_req && imem_gnt) begin
                    if (first_grant_sr < 0)
                        first_grant_sr = since_rst;
                    it.pc    = exp_pc;
                    it.epoch = epoch;
                    infl_q.push_back(it);
                    m.addr  = imem_addr;
                    m.ready = cyc + int'($urandom_range(lat_max, lat_min));
                    mem_q.push_back(m);
                    exp_pc += 32'd4;
                end
                if (imem_recv && infl_q.size() > 0) begin
                    it = infl_q.pop_front();
                    if (!cf_ack && it.epoch == epoch) begin
                        w.data = imem_rdata;
                        w.pc   = it.pc;
                        w.err  = imem_error;
                        exp_q.push_back(w);
                    end
                end
                if (cf_ack) begin
                    epoch++;
                    exp_q.delete();
                    exp_pc = cf_target & ~32'd3;
                end
                prev_pending = imem_req && !imem_gnt;
                prev_ack     = cf_ack;
            end
        end
    end

    initial begin : stimulus
        bit got;
        run(3);
        rst_drive = 1'b1;

        // Streaming fetch from reset with single-cycle memory.
        gnt_pct = 100;
        run(30);
        check("first_fetch_delay", first_grant_sr, 2);

        // Decode stalled: issue must stop once buffer plus in-flight reach DEPTH.
        ready_pct = 0;
        run(20);
        #2;
        check("stall_req_low", imem_req, 1'b0);
        check("stall_valid", f_valid, 1'b1);
        ready_pct = 100;
        run(20);

        // Reset with two fetches in flight.
        hold_recv = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            #2;
            if (mem_q.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        check("two_in_flight", got, 1'b1);
        rst_drive = 1'b0;
        step();
        rst_drive = 1'b1;
        step();
        #2;
        check("rst_idle_req", imem_req, 1'b0);
        check("rst_idle_valid", f_valid, 1'b0);
        check("rst_idle_flush", flush, 1'b0);

        // Three granted, none returned, then redirect to an unaligned target.
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            #2;
            if (mem_q.size() >= 3) begin
                got = 1'b1;
                break;
            end
        end
        check("three_in_flight", got, 1'b1);
        check("restart_fetch_delay", first_grant_sr, 2);
        gnt_pct = 0;
        force_cf = 1'b1;
        force_target = 32'h0000_1002;
        step();
        #2;
        check("redirect_ack", cf_ack, 1'b1);
        force_cf = 1'b0;
        step();
        #2;
        check("redirect_flush", flush, 1'b1);
        hold_recv = 1'b0;
        gnt_pct = 100;
        run(20);

        // Redirect against an ungranted pending request.
        gnt_pct = 0;
        run(3);
        force_cf = 1'b1;
        force_target = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            step();
            #2;
            check("ack_blocked", cf_ack, 1'b0);
        end
        gnt_pct = 100;
        step();
        #2;
        check("ack_on_grant", cf_ack, 1'b1);
        force_cf = 1'b0;
        run(20);

        // Randomized traffic with random latency and redirects.
        gnt_pct = 70; recv_pct = 60; ready_pct = 70; cf_pct = 4;
        lat_min = 1; lat_max = 4;
        run(2500);

        // Writeback stall: cf_req held for several cycles.
        cf_pct = 0; gnt_pct = 50; ready_pct = 50;
        force_cf = 1'b1;
        force_target = 32'hFFFF_FFF8;
        run(6);
        force_cf = 1'b0;
        gnt_pct = 100; ready_pct = 100;
        run(40);

        // Drain all in-flight and buffered words.
        gnt_pct = 0; recv_pct = 100;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            #2;
            if (infl_q.size() == 0 && exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        check("drain", got, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
